// File: rtl/aib_mac_link_pkg.sv
// Shared types for the AIB MAC-side link bring-up controller.
// State encoding is visible on state_o, so the values are fixed.
package aib_mac_link_pkg;

    localparam int DROP_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST_DLY = 3'd1,
        ST_MAC_RDY = 3'd2,
        ST_LOCK    = 3'd3,
        ST_ALIGN   = 3'd4,
        ST_UP      = 3'd5,
        ST_FAIL    = 3'd6
    } link_state_e;

    typedef struct packed {
        logic adapter_rstn;
        logic mac_rdy;
        logic lock_req;
        logic data_en;
    } link_out_t;

    function automatic link_out_t decode_outputs(input link_state_e st);
        link_out_t o;
        o.adapter_rstn = st inside {ST_MAC_RDY, ST_LOCK, ST_ALIGN, ST_UP, ST_FAIL};
        o.mac_rdy      = st inside {ST_MAC_RDY, ST_LOCK, ST_ALIGN, ST_UP};
        o.lock_req     = st inside {ST_LOCK, ST_ALIGN, ST_UP};
        o.data_en      = (st == ST_UP);
        return o;
    endfunction

endpackage

// File: rtl/aib_mac_sync2.sv
// Parameterized-width two-flop synchronizer, asynchronous active-low reset.
module aib_mac_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/aib_mac_link_ctrl.sv
// MAC-side channel bring-up FSM: reset delay, MAC ready, DCC/DLL lock, RX
// alignment, then data enable; tracks timeouts and link drops.
module aib_mac_link_ctrl
    import aib_mac_link_pkg::*;
#(
    parameter int RSTN_DLY = 16,
    parameter int TIMEOUT  = 4096,
    parameter int CNTW     = $clog2(((RSTN_DLY > TIMEOUT) ? RSTN_DLY : TIMEOUT) + 1)
) (
    input  logic                  m_wr_clk,
    input  logic                  rst_n,
    input  logic                  i_conf_done,
    input  logic                  por,
    input  logic                  i_retrain,
    input  logic                  fs_mac_rdy,
    input  logic                  tx_transfer_en,
    input  logic                  rx_transfer_en,
    input  logic                  rx_align_done,
    output logic                  ns_adapter_rstn,
    output logic                  ns_mac_rdy,
    output logic                  tx_dcc_dll_lock_req,
    output logic                  rx_dcc_dll_lock_req,
    output logic                  data_en,
    output logic                  link_fail,
    output logic [DROP_CNT_W-1:0] link_drop_cnt,
    output logic [2:0]            state_o
);

    localparam logic [CNTW-1:0] RST_LAST = CNTW'(RSTN_DLY - 1);
    localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT - 1);

    logic [3:0] async_in, sync_in;
    logic       s_fs_rdy, s_tx_en, s_rx_en, s_align;

    assign async_in = {rx_align_done, rx_transfer_en, tx_transfer_en, fs_mac_rdy};

    aib_mac_sync2 #(.W(4)) u_sync (
        .clk   (m_wr_clk),
        .rst_n (rst_n),
        .d     (async_in),
        .q     (sync_in)
    );

    assign {s_align, s_rx_en, s_tx_en, s_fs_rdy} = sync_in;

    link_state_e           state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  fail_q, fail_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    link_out_t             out_q, out_d;
    logic                  wait_ok;
    link_state_e           wait_nxt;

    // Exit condition and successor for the three timed wait states.
    always_comb begin
        wait_ok  = 1'b0;
        wait_nxt = ST_FAIL;
        case (state_q)
            ST_MAC_RDY: begin wait_ok = s_fs_rdy;            wait_nxt = ST_LOCK;  end
            ST_LOCK:    begin wait_ok = s_tx_en && s_rx_en;  wait_nxt = ST_ALIGN; end
            ST_ALIGN:   begin wait_ok = s_align;             wait_nxt = ST_UP;    end
            default:    ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        drop_d  = drop_q;
        if (!i_conf_done || por) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            fail_d  = 1'b0;
        end else if (i_retrain && state_q != ST_IDLE && state_q != ST_RST_DLY) begin
            state_d = ST_RST_DLY;
            cnt_d   = '0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RST_DLY;
                    cnt_d   = '0;
                end
                ST_RST_DLY: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_MAC_RDY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                // Exit is tested before the timeout so a same-cycle race advances.
                ST_MAC_RDY, ST_LOCK, ST_ALIGN: begin
                    if (wait_ok) begin
                        state_d = wait_nxt;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = ST_FAIL;
                        cnt_d   = '0;
                        fail_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                ST_UP: begin
                    if (!(s_fs_rdy && s_tx_en && s_rx_en)) begin
                        state_d = ST_RST_DLY;
                        cnt_d   = '0;
                        if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
                    end
                end
                ST_FAIL: ;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign out_d = decode_outputs(state_d);

    always_ff @(posedge m_wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            drop_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            drop_q  <= drop_d;
            out_q   <= out_d;
        end
    end

    assign ns_adapter_rstn     = out_q.adapter_rstn;
    assign ns_mac_rdy          = out_q.mac_rdy;
    assign tx_dcc_dll_lock_req = out_q.lock_req;
    assign rx_dcc_dll_lock_req = out_q.lock_req;
    assign data_en             = out_q.data_en;
    assign link_fail           = fail_q;
    assign link_drop_cnt       = drop_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_aib_mac_link_ctrl.sv
// Bench for aib_mac_link_ctrl: directed bring-up scenarios plus random traffic,
// checked every cycle against a timestamp-based behavioural model.
module tb_aib_mac_link_ctrl;

    localparam int RSTN_DLY = 8;
    localparam int TIMEOUT  = 64;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic rst_n, conf, por, retrain, fs, txe, rxe, ald;
    logic ns_adapter_rstn, ns_mac_rdy, tx_req, rx_req, data_en, link_fail;
    logic [7:0] link_drop_cnt;
    logic [2:0] state_o;

    aib_mac_link_ctrl #(.RSTN_DLY(RSTN_DLY), .TIMEOUT(TIMEOUT)) dut (
        .m_wr_clk            (gclk),
        .rst_n               (rst_n),
        .i_conf_done         (conf),
        .por                 (por),
        .i_retrain           (retrain),
        .fs_mac_rdy          (fs),
        .tx_transfer_en      (txe),
        .rx_transfer_en      (rxe),
        .rx_align_done       (ald),
        .ns_adapter_rstn     (ns_adapter_rstn),
        .ns_mac_rdy          (ns_mac_rdy),
        .tx_dcc_dll_lock_req (tx_req),
        .rx_dcc_dll_lock_req (rx_req),
        .data_en             (data_en),
        .link_fail           (link_fail),
        .link_drop_cnt       (link_drop_cnt),
        .state_o             (state_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: state as int, timers as "edge number when the state was entered".
    int         m_st, m_enter, m_k, m_drop;
    bit         m_fail;
    logic [3:0] h0, h1;  // input values sampled 2 and 1 edges ago

    task automatic model_reset();
        m_st = 0; m_enter = 0; m_k = 0; m_drop = 0; m_fail = 0;
        h0 = '0; h1 = '0;
    endtask

    task automatic model_step();
        logic [3:0] s;
        int ns;
        bit ok;
        s  = h0;
        h0 = h1;
        h1 = {ald, rxe, txe, fs};
        m_k++;
        ns = m_st;
        if (!conf || por) begin
            ns = 0; m_fail = 0;
        end else if (retrain && m_st >= 2) begin
            ns = 1; m_fail = 0;
        end else begin
            case (m_st)
                0: ns = 1;
                1: if (m_k - m_enter == RSTN_DLY) ns = 2;
                2, 3, 4: begin
                    ok = (m_st == 2) ? s[0] : (m_st == 3) ? (s[1] && s[2]) : s[3];
                    if (ok) ns = m_st + 1;
                    else if (m_k - m_enter == TIMEOUT) begin ns = 6; m_fail = 1; end
                end
                5: if (!(s[0] && s[1] && s[2])) begin
                    ns = 1;
                    if (m_drop < 255) m_drop++;
                end
                default: ;
            endcase
        end
        if (ns != m_st) m_enter = m_k;
        m_st = ns;
    endtask

    task automatic check_all();
        chk("state",    state_o,         m_st);
        chk("adp_rstn", ns_adapter_rstn, (m_st >= 2 && m_st <= 6));
        chk("mac_rdy",  ns_mac_rdy,      (m_st >= 2 && m_st <= 5));
        chk("tx_req",   tx_req,          (m_st >= 3 && m_st <= 5));
        chk("rx_req",   rx_req,          (m_st >= 3 && m_st <= 5));
        chk("data_en",  data_en,         (m_st == 5));
        chk("fail",     link_fail,       m_fail);
        chk("drops",    link_drop_cnt,   m_drop);
    endtask

    task automatic tick();
        @(posedge gclk);
        model_step();
        @(negedge gclk);
        check_all();
    endtask

    task automatic wait_st(input int st, input int lim, input string tag);
        int n = 0;
        while (m_st != st && n < lim) begin tick(); n++; end
        chk(tag, state_o, st);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rstn"},  ns_adapter_rstn, 0);
        chk({tag, "_mrdy"},  ns_mac_rdy, 0);
        chk({tag, "_req"},   {tx_req, rx_req}, 0);
        chk({tag, "_den"},   data_en, 0);
        chk({tag, "_fail"},  link_fail, 0);
        chk({tag, "_drops"}, link_drop_cnt, 0);
        chk({tag, "_state"}, state_o, 0);
    endtask

    initial begin
        int c_rstn, c_den, n;
        rst_n = 1'b0; conf = 0; por = 0; retrain = 0;
        fs = 0; txe = 0; rxe = 0; ald = 0;
        model_reset();
        #22;
        chk_all_zero("reset");
        @(negedge gclk);
        rst_n = 1'b1;

        // Nominal bring-up; iteration c drives the inputs for cycle c.
        c_rstn = -1; c_den = -1;
        conf = 1;
        for (int c = 0; c < 70; c++) begin
            fs  = (c >= 20);
            txe = (c >= 40);
            rxe = (c >= 40);
            ald = (c >= 60);
            tick();
            if (c_rstn < 0 && ns_adapter_rstn) c_rstn = c + 1;
            if (c_den < 0 && data_en)          c_den  = c + 1;
        end
        chk("rstn_rise_cycle", c_rstn, RSTN_DLY + 1);
        chk("data_en_cycle",   c_den,  63);
        chk("nominal_state",   state_o, 5);

        // One-cycle rx_transfer_en drop while UP.
        rxe = 0; tick(); rxe = 1; tick(); tick();
        chk("drop_state", state_o, 1);
        chk("drop_cnt1",  link_drop_cnt, 1);
        chk("drop_den",   data_en, 0);
        chk("drop_rstn",  ns_adapter_rstn, 0);
        for (int i = 1; i < 256; i++) begin
            wait_st(5, 60, "relink");
            rxe = 0; tick(); rxe = 1; tick(); tick();
        end
        chk("drop_sat", link_drop_cnt, 255);

        // Override while UP.
        wait_st(5, 60, "relink_ovr");
        por = 1; tick(); por = 0;
        chk("ovr_state", state_o, 0);
        chk("ovr_den",   data_en, 0);
        chk("ovr_rstn",  ns_adapter_rstn, 0);
        chk("ovr_mrdy",  ns_mac_rdy, 0);
        chk("ovr_req",   {tx_req, rx_req}, 0);
        chk("ovr_drops", link_drop_cnt, 255);

        // LOCK timeout with transfer enables held low.
        txe = 0; rxe = 0;
        wait_st(3, 100, "to_lock");
        n = 0;
        while (state_o != 3'd6 && n < 200) begin tick(); n++; end
        chk("lock_timeout_cycles", n, TIMEOUT);
        chk("lock_to_fail", link_fail, 1);
        chk("lock_to_req",  {tx_req, rx_req}, 0);
        repeat (5) tick();
        chk("fail_hold", state_o, 6);
        retrain = 1; tick(); retrain = 0;
        chk("retrain_fail", link_fail, 0);
        chk("retrain_state", state_o, 1);

        // Exit condition coincides with the last timeout count.
        txe = 1; rxe = 1; ald = 0;
        wait_st(4, 100, "to_align");
        repeat (TIMEOUT - 3) tick();
        ald = 1;
        repeat (3) tick();
        chk("race_win", state_o, 5);

        // One cycle too late.
        ald = 0; retrain = 1; tick(); retrain = 0;
        wait_st(4, 100, "to_align2");
        repeat (TIMEOUT - 2) tick();
        ald = 1;
        repeat (2) tick();
        chk("race_late", state_o, 6);
        chk("race_late_fail", link_fail, 1);

        // Asynchronous reset mid-LOCK.
        txe = 0; retrain = 1; tick(); retrain = 0;
        wait_st(3, 100, "to_lock2");
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(negedge gclk);
        rst_n = 1'b1;
        txe = 1;
        wait_st(5, 100, "rebringup");
        chk("rebringup_drops", link_drop_cnt, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            conf    = ($urandom_range(0, 199) != 0);
            por     = ($urandom_range(0, 299) == 0);
            retrain = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) fs  = ~fs;
            if ($urandom_range(0, 39) == 0) txe = ~txe;
            if ($urandom_range(0, 39) == 0) rxe = ~rxe;
            if ($urandom_range(0, 29) == 0) ald = ~ald;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
